// File: rtl/seq_alu.sv
// Registered multi-cycle ALU with valid/ready handshake on input and output.
// Single-cycle ops finish on the accept edge; MUL/DIV/MOD iterate W cycles.
module seq_alu #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         of_und,
  output logic         err,
  output logic         zero
);

  localparam int SHW = $clog2(W);
  localparam int EXW = W + (1 << SHW);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3, OP_MOD = 4'd4,
    OP_AND = 4'd5, OP_OR  = 4'd6, OP_XOR = 4'd7, OP_SHL = 4'd8, OP_SHR = 4'd9
  } op_e;

  state_e         r_state;
  logic           r_in_ready, r_out_valid;
  logic [W-1:0]   r_result;
  logic           r_of, r_err, r_zero;
  logic [3:0]     r_op;
  logic [W-1:0]   r_b;
  logic [SHW-1:0] r_cnt;
  logic [2*W-1:0] r_acc, r_mcand;
  logic [W-1:0]   r_mplier, r_rem, r_quo;

  logic [W:0]     w_sum;
  logic [EXW-1:0] w_shl;
  logic [W-1:0]   w_res;
  logic           w_of, w_err, w_multi;
  logic [2*W-1:0] w_acc_nxt;
  logic [W:0]     w_shift, w_diff;
  logic [W-1:0]   w_rem_nxt, w_quo_nxt, w_it_res;
  logic           w_it_of;

  always_comb begin
    w_sum   = {1'b0, a} + {1'b0, b};
    w_shl   = EXW'(a) << b[SHW-1:0];
    w_res   = '0;
    w_of    = 1'b0;
    w_err   = 1'b0;
    w_multi = 1'b0;
    case (op)
      OP_ADD: begin w_res = w_sum[W-1:0]; w_of = w_sum[W]; end
      OP_SUB: begin w_res = a - b; w_of = (a < b); end
      OP_MUL: w_multi = 1'b1;
      OP_DIV, OP_MOD: begin
        if (b == '0) begin w_err = 1'b1; w_res = '1; end
        else w_multi = 1'b1;
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_SHL: begin w_res = w_shl[W-1:0]; w_of = |w_shl[EXW-1:W]; end
      OP_SHR: w_res = a >> b[SHW-1:0];
      default: w_err = 1'b1;
    endcase
  end

  // One iteration of both datapaths; the final iteration's values feed the result directly.
  always_comb begin
    w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_shift   = {r_rem, r_quo[W-1]};
    w_diff    = w_shift - {1'b0, r_b};
    if (w_shift >= {1'b0, r_b}) begin
      w_rem_nxt = w_diff[W-1:0];
      w_quo_nxt = {r_quo[W-2:0], 1'b1};
    end else begin
      w_rem_nxt = w_shift[W-1:0];
      w_quo_nxt = {r_quo[W-2:0], 1'b0};
    end
    w_it_of  = 1'b0;
    w_it_res = w_rem_nxt;
    if (r_op == OP_MUL) begin
      w_it_res = w_acc_nxt[W-1:0];
      w_it_of  = |w_acc_nxt[2*W-1:W];
    end else if (r_op == OP_DIV) begin
      w_it_res = w_quo_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_of        <= 1'b0;
      r_err       <= 1'b0;
      r_zero      <= 1'b0;
      r_op        <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_op       <= op;
            r_b        <= b;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= {{W{1'b0}}, a};
            r_mplier   <= b;
            r_rem      <= '0;
            r_quo      <= a;
            r_in_ready <= 1'b0;
            if (w_multi) begin
              r_state <= S_BUSY;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_of        <= w_of;
              r_err       <= w_err;
              r_zero      <= (w_res == '0) && !w_err;
            end
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_rem    <= w_rem_nxt;
          r_quo    <= w_quo_nxt;
          r_cnt    <= r_cnt + SHW'(1);
          if (r_cnt == CNT_LAST) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_it_res;
            r_of        <= w_it_of;
            r_err       <= 1'b0;
            r_zero      <= (w_it_res == '0);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign of_und    = r_of;
  assign err       = r_err;
  assign zero      = r_zero;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_seq_alu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [3:0]   op;
  logic         of_und, err, zero;

  int checks = 0;
  int errors = 0;

  seq_alu #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .of_und(of_und), .err(err), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic; d = extra cycles before out_valid.
  function automatic void model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                input logic [3:0] o, output longint r,
                                output bit f, output bit e, output int d);
    longint x, y, full, p;
    int sh;
    x = ai; y = bi; full = longint'(1) << W;
    sh = int'(y % (1 << $clog2(W)));
    r = 0; f = 0; e = 0; d = 0;
    case (o)
      4'd0: begin r = (x + y) % full; f = (x + y) >= full; end
      4'd1: begin r = (x - y + full) % full; f = x < y; end
      4'd2: begin r = (x * y) % full; f = (x * y) >= full; d = W; end
      4'd3: if (y == 0) begin e = 1; r = full - 1; end else begin r = x / y; d = W; end
      4'd4: if (y == 0) begin e = 1; r = full - 1; end else begin r = x % y; d = W; end
      4'd5: r = ai & bi;
      4'd6: r = ai | bi;
      4'd7: r = ai ^ bi;
      4'd8: begin p = x * (longint'(1) << sh); r = p % full; f = p >= full; end
      4'd9: r = x / (longint'(1) << sh);
      default: e = 1;
    endcase
  endfunction

  int     cyc = 0;
  bit     m_active = 0;
  int     m_acc = 0;
  int     m_delay = 0;
  longint m_res = 0;
  bit     m_of = 0, m_err = 0;

  always @(posedge clk) begin
    bit done_old;
    done_old = m_active && ((cyc - m_acc) >= m_delay);
    cyc++;
    if (!rst_n) m_active = 0;
    else if (m_active) begin
      if (done_old && out_ready) m_active = 0;
    end else if (in_valid) begin
      m_active = 1;
      m_acc = cyc;
      model(a, b, op, m_res, m_of, m_err, m_delay);
    end
  end

  always @(negedge clk) begin
    bit mv;
    if (cyc > 0) begin
      mv = m_active && ((cyc - m_acc) >= m_delay);
      chk("in_ready", in_ready, !m_active);
      chk("out_valid", out_valid, mv);
      if (mv) begin
        chk("result", result, m_res);
        chk("of_und", of_und, m_of);
        chk("err", err, m_err);
        chk("zero", zero, (m_res == 0) && !m_err);
      end
    end
  end

  task automatic do_op(input logic [3:0] o, input int av, input int bv, input int er,
                       input int eo, input int ee, input int ez, input int el, input int hold);
    int n;
    logic [W-1:0] ta, tb;
    ta = av[W-1:0]; tb = bv[W-1:0];
    @(negedge clk);
    a = ta; b = tb; op = o; in_valid = 1;
    @(negedge clk);
    in_valid = 0; a = ~ta; b = ~tb; op = 4'hF;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, el);
    chk("lit_result", result, er);
    chk("lit_of_und", of_und, eo);
    chk("lit_err", err, ee);
    chk("lit_zero", zero, ez);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_result", result, er);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("ack_in_ready", in_ready, 1);
    chk("ack_out_valid", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 0; a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {of_und, err, zero}, 0);
    rst_n = 1;

    //     op     a    b    res  of err zero lat hold
    do_op(4'd0,   5,  10,  15,  0, 0, 0, 1, 0);
    do_op(4'd0, 200, 200, 144,  1, 0, 0, 1, 0);
    do_op(4'd1,  14,  20, 250,  1, 0, 0, 1, 0);
    do_op(4'd1,  14,   2,  12,  0, 0, 0, 1, 0);
    do_op(4'd1,  14,  14,   0,  0, 0, 1, 1, 0);
    do_op(4'd2, 100,   6,  88,  1, 0, 0, 9, 0);
    do_op(4'd2,  14,  10, 140,  0, 0, 0, 9, 0);
    do_op(4'd2, 255, 255,   1,  1, 0, 0, 9, 0);
    do_op(4'd3, 100,   6,  16,  0, 0, 0, 9, 0);
    do_op(4'd4, 100,   6,   4,  0, 0, 0, 9, 0);
    do_op(4'd3,   0,  10,   0,  0, 0, 1, 9, 0);
    do_op(4'd3, 255,   1, 255,  0, 0, 0, 9, 0);
    do_op(4'd4, 255,  16,  15,  0, 0, 0, 9, 0);
    do_op(4'd3,  14,   0, 255,  0, 1, 0, 1, 0);
    do_op(4'd4,  14,   0, 255,  0, 1, 0, 1, 0);
    do_op(4'd12, 14,   3,   0,  0, 1, 0, 1, 0);
    do_op(4'd5,  14,  12,  12,  0, 0, 0, 1, 0);
    do_op(4'd6,  14,  12,  14,  0, 0, 0, 1, 0);
    do_op(4'd8, 200,   3,  64,  1, 0, 0, 1, 0);
    do_op(4'd8,   3,   2,  12,  0, 0, 0, 1, 0);
    do_op(4'd9, 200,  11,  25,  0, 0, 0, 1, 0);
    do_op(4'd7,  14,  12,   2,  0, 0, 0, 1, 5);

    // Reset in cycle 4 of a multiply discards it.
    @(negedge clk);
    a = 8'd100; b = 8'd6; op = 4'd2; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk("busy_in_ready", in_ready, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_result", result, 0);
    chk("mrst_flags", {of_und, err, zero}, 0);
    do_op(4'd0, 1, 1, 2, 0, 0, 0, 1, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
